// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB register slave: 14 R/W registers, write counter and ID, fixed wait states.
module apb_reg_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_A000,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        pclk,
   input  logic        preset_n,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic [31:0] paddr_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
   output logic [31:0] prdata_o,
   output logic        pready_o,
   output logic        pslverr_o,
   output logic [31:0] ctrl_o
);

   localparam logic [31:0] ID_VALUE  = 32'hA9B0_0001;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] regs_q [14];
   logic [31:0] wcnt_q, wcnt_d;

   logic        access;
   logic [3:0]  idx;
   logic        addr_err;
   logic        err;
   logic        wr_ok;
   logic [31:0] rdata;

   // Address and data are taken from the live bus in the response cycle only.
   assign access   = (state_q == ST_RESP) && psel_i && penable_i;
   assign idx      = paddr_i[5:2];
   assign addr_err = (paddr_i[31:6] != BASE_ADDR[31:6]) || (paddr_i[1:0] != 2'b00);
   assign err      = addr_err || (pwrite_i && (idx >= 4'd14));
   assign wr_ok    = access && pwrite_i && !err;
   assign wcnt_d   = wcnt_q + 32'd1;
   assign ctrl_o   = regs_q[0];

   always_comb begin
      rdata = '0;
      if (idx == 4'd15)
         rdata = ID_VALUE;
      else if (idx == 4'd14)
         rdata = wcnt_q;
      else
         rdata = regs_q[idx];
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (psel_i) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (!psel_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1)
                  state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      pready_o  = access;
      pslverr_o = access && err;
      prdata_o  = (access && !pwrite_i && !err) ? rdata : 32'h0;
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         for (int i = 0; i < 14; i++)
            regs_q[i] <= '0;
         wcnt_q <= '0;
      end else if (wr_ok) begin
         regs_q[idx] <= pwdata_i;
         wcnt_q      <= wcnt_d;
      end
   end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - scoreboard bench for apb_reg_slave with WAIT_CYCLES 1, 0 and 3.
module tb_apb_reg_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        psel [3];
   logic        penable [3];
   logic        pwrite [3];
   logic [31:0] paddr [3];
   logic [31:0] pwdata [3];
   logic [31:0] prdata [3];
   logic [31:0] ctrl [3];
   logic        pready [3];
   logic        pslverr [3];

   typedef struct {
      int          d;
      logic        err;
      logic [31:0] rd;
   } exp_t;

   exp_t sbq [$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   bit   held [3];

   always #5 clk = ~clk;

   apb_reg_slave #(.WAIT_CYCLES(1)) dut0 (
      .pclk(clk), .preset_n(rst_n), .psel_i(psel[0]), .penable_i(penable[0]),
      .paddr_i(paddr[0]), .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]),
      .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]), .ctrl_o(ctrl[0]));

   apb_reg_slave #(.WAIT_CYCLES(0)) dut1 (
      .pclk(clk), .preset_n(rst_n), .psel_i(psel[1]), .penable_i(penable[1]),
      .paddr_i(paddr[1]), .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]),
      .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]), .ctrl_o(ctrl[1]));

   apb_reg_slave #(.WAIT_CYCLES(3)) dut2 (
      .pclk(clk), .preset_n(rst_n), .psel_i(psel[2]), .penable_i(penable[2]),
      .paddr_i(paddr[2]), .pwrite_i(pwrite[2]), .pwdata_i(pwdata[2]),
      .prdata_o(prdata[2]), .pready_o(pready[2]), .pslverr_o(pslverr[2]), .ctrl_o(ctrl[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (pready[d] === 1'b1) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected actual=pready dut%0d expected=no response", d);
            end else begin
               mon_e = sbq.pop_front();
               chk("sb_dut", d, mon_e.d);
               chk("sb_pslverr", {31'b0, pslverr[d]}, {31'b0, mon_e.err});
               chk("sb_prdata", prdata[d], mon_e.rd);
            end
         end else begin
            chk("idle_prdata", prdata[d], 32'h0);
            chk("idle_pslverr", {31'b0, pslverr[d]}, 32'h0);
         end
      end
   end

   task automatic apb(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input bit eerr, input logic [31:0] erd, input int eacc, input bit hold = 1'b0);
      int   n;
      exp_t e;
      e.d = d; e.err = eerr; e.rd = erd;
      sbq.push_back(e);
      if (!held[d]) begin
         @(posedge clk); #1;
         psel[d] = 1'b1; penable[d] = 1'b0;
      end
      held[d] = 1'b0;
      pwrite[d] = !wr; paddr[d] = 32'hFFFF_FFFC; pwdata[d] = ~wd;
      @(posedge clk); #1;
      penable[d] = 1'b1; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
      n = 1;
      @(negedge clk);
      while (pready[d] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("access_cycles", n, eacc);
      @(posedge clk); #1;
      penable[d] = 1'b0;
      if (hold) held[d] = 1'b1;
      else psel[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = 0; pwdata[d] = 0; held[d] = 0;
      end
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_pready", {31'b0, pready[0]}, 32'h0);
      chk("rst_pslverr", {31'b0, pslverr[0]}, 32'h0);
      chk("rst_prdata", prdata[0], 32'h0);
      chk("rst_ctrl", ctrl[0], 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      apb(0, 1, 32'hA000, 32'hDEAD_BEEF, 0, 32'h0, 2);
      chk("ctrl_after_write", ctrl[0], 32'hDEAD_BEEF);
      apb(0, 0, 32'hA03C, 32'h0, 0, 32'hA9B0_0001, 2);
      apb(0, 0, 32'hA038, 32'h0, 0, 32'h1, 2);
      apb(0, 1, 32'hA004, 32'h1234_5678, 0, 32'h0, 2);
      apb(0, 1, 32'hA034, 32'h0000_55AA, 0, 32'h0, 2);
      apb(0, 0, 32'hA038, 32'h0, 0, 32'h3, 2);
      apb(0, 0, 32'hA004, 32'h0, 0, 32'h1234_5678, 2);
      apb(0, 0, 32'hA034, 32'h0, 0, 32'h0000_55AA, 2);

      apb(0, 1, 32'hA03C, 32'h1, 1, 32'h0, 2);
      apb(0, 1, 32'hA002, 32'h1, 1, 32'h0, 2);
      apb(0, 1, 32'hB000, 32'h1, 1, 32'h0, 2);
      apb(0, 1, 32'hA038, 32'h1, 1, 32'h0, 2);
      apb(0, 0, 32'hA038, 32'h0, 0, 32'h3, 2);
      apb(0, 0, 32'hA000, 32'h0, 0, 32'hDEAD_BEEF, 2);
      apb(0, 0, 32'hA002, 32'h0, 1, 32'h0, 2);
      apb(0, 0, 32'hB000, 32'h0, 1, 32'h0, 2);
      apb(0, 0, 32'hA03C, 32'h0, 0, 32'hA9B0_0001, 2);

      apb(0, 1, 32'hA014, 32'hA5A5_0F0F, 0, 32'h0, 2, 1);
      apb(0, 0, 32'hA014, 32'h0, 0, 32'hA5A5_0F0F, 2, 1);
      apb(0, 0, 32'hA038, 32'h0, 0, 32'h4, 2);

      @(negedge clk);
      force dut0.wcnt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut0.wcnt_q;
      apb(0, 0, 32'hA038, 32'h0, 0, 32'hFFFF_FFFF, 2);
      apb(0, 1, 32'hA018, 32'h0000_0018, 0, 32'h0, 2);
      apb(0, 0, 32'hA038, 32'h0, 0, 32'h0, 2);

      apb(1, 1, 32'hA008, 32'h0BAD_F00D, 0, 32'h0, 1);
      apb(1, 0, 32'hA008, 32'h0, 0, 32'h0BAD_F00D, 1);
      apb(1, 0, 32'hA038, 32'h0, 0, 32'h1, 1);

      apb(2, 1, 32'hA00C, 32'h1357_9BDF, 0, 32'h0, 4);
      @(posedge clk); #1;
      psel[2] = 1; penable[2] = 0; pwrite[2] = 1; paddr[2] = 32'hA00C; pwdata[2] = 32'hFFFF_0000;
      @(posedge clk); #1 penable[2] = 1;
      @(negedge clk) chk("abort_pready_1", {31'b0, pready[2]}, 32'h0);
      @(posedge clk); #1 psel[2] = 0; penable[2] = 0;
      @(negedge clk) chk("abort_pready_2", {31'b0, pready[2]}, 32'h0);
      apb(2, 0, 32'hA00C, 32'h0, 0, 32'h1357_9BDF, 4);
      apb(2, 0, 32'hA038, 32'h0, 0, 32'h1, 4);

      // Reset pulse while dut0 sits in its wait state.
      @(posedge clk); #1;
      psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 32'hA004; pwdata[0] = 32'hCAFE_0000;
      @(posedge clk); #1 penable[0] = 1;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_pready", {31'b0, pready[0]}, 32'h0);
      chk("midrst_pslverr", {31'b0, pslverr[0]}, 32'h0);
      chk("midrst_prdata", prdata[0], 32'h0);
      chk("midrst_ctrl", ctrl[0], 32'h0);
      psel[0] = 0; penable[0] = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      apb(0, 0, 32'hA004, 32'h0, 0, 32'h0, 2);
      apb(0, 0, 32'hA038, 32'h0, 0, 32'h0, 2);
      apb(0, 1, 32'hA004, 32'h7777_0001, 0, 32'h0, 2);
      apb(0, 0, 32'hA004, 32'h0, 0, 32'h7777_0001, 2);

      repeat (3) @(negedge clk);
      chk("sb_drained", sbq.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
